// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
// Module-specific widths are derived from these helpers inside each module.
package pwm_pkg;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_RES_BITS = 4;
    localparam int PERIOD       = 1 << DEF_RES_BITS;
    localparam int MAX_DUTY     = PERIOD;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Width needed to index n items, never less than one bit.
    function automatic int bits(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int period(input int res_bits);
        return 1 << res_bits;
    endfunction

    function automatic int off(input int c, input int channels, input int res_bits,
                               input int stagger);
        return (stagger != 0) ? (c * period(res_bits)) / channels : 0;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: saturating shadow duty, period-aligned active duty and
// a registered compare against the phase-shifted shared counter.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int RES_BITS = 4,
    parameter int OFFSET   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                wr,
    input  logic [RES_BITS:0]   wr_duty,
    input  logic                wrap,
    input  logic [RES_BITS-1:0] cnt,
    output logic                pwm
);

    localparam logic [RES_BITS:0]   MAX = (RES_BITS + 1)'(period(RES_BITS));
    localparam logic [RES_BITS-1:0] OFF = RES_BITS'(OFFSET);

    logic [RES_BITS:0]   shadow_q;
    logic [RES_BITS:0]   active_q;
    logic [RES_BITS-1:0] pos;

    // Modular add: the counter width gives the wrap for free.
    assign pos = cnt + OFF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wr) shadow_q <= (wr_duty > MAX) ? MAX : wr_duty;
            // Non-blocking: a write on the wrap edge lands one period later.
            if (wrap) active_q <= shadow_q;
            pwm <= en && ({1'b0, pos} < active_q);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM top: shared prescaler and period counter, write decode,
// and one pwm_channel per output.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter  int CHANNELS = 8,
    parameter  int RES_BITS = 4,
    parameter  int DIV      = 1,
    parameter  int STAGGER  = 0,
    localparam int CH_W     = bits(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [RES_BITS:0]   wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam int            PW       = bits(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0]       presc_q;
    logic [RES_BITS-1:0] cnt_q;
    logic                tick;
    logic                wrap;
    logic [CHANNELS-1:0] wr_sel;

    assign tick = en && (presc_q == PRE_LAST);
    assign wrap = tick && (cnt_q == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            cnt_q        <= '0;
            period_start <= 1'b0;
        end else begin
            if (en) presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) cnt_q <= cnt_q + 1'b1;
            period_start <= wrap;
        end
    end

    // Addresses at or above CHANNELS match no channel and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_en && (wr_ch == CH_W'(c))) wr_sel[c] = 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pwm_channel #(
            .RES_BITS(RES_BITS),
            .OFFSET  (off(c, CHANNELS, RES_BITS, STAGGER))
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .wr     (wr_sel[c]),
            .wr_duty(wr_duty),
            .wrap   (wrap),
            .cnt    (cnt_q),
            .pwm    (pwm_out[c])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: three configurations on one clock,
// compared cycle by cycle against a behavioural model plus duty/phase counts.
module tb_pwm_multi;

    localparam int NCH  [3] = '{8, 6, 4};
    localparam int NDIV [3] = '{1, 3, 1};
    localparam int NSTG [3] = '{0, 0, 1};
    localparam int NCHW [3] = '{3, 3, 2};
    localparam int P = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  wr_sel = '0;
    logic [3:0]  wr_ch = '0;
    logic [4:0]  wr_duty = '0;
    logic [7:0]  pwm0;
    logic [5:0]  pwm1;
    logic [3:0]  pwm2;
    logic        ps0, ps1, ps2;
    logic [20:0] obs;

    int tests = 0;
    int fails = 0;

    // Model state
    int          m_presc [3];
    int          m_cnt [3];
    int          m_shadow [3][16];
    int          m_active [3][16];
    logic [15:0] m_pwm [3];
    logic        m_ps [3];

    always #5 clk = ~clk;
    assign obs = {ps2, pwm2, ps1, pwm1, ps0, pwm0};

    pwm_multi #(.CHANNELS(8), .RES_BITS(4), .DIV(1), .STAGGER(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .wr_en(wr_sel[0]), .wr_ch(wr_ch[2:0]),
        .wr_duty(wr_duty), .pwm_out(pwm0), .period_start(ps0)
    );
    pwm_multi #(.CHANNELS(6), .RES_BITS(4), .DIV(3), .STAGGER(0)) dut1 (
        .clk(clk), .reset(reset), .en(en), .wr_en(wr_sel[1]), .wr_ch(wr_ch[2:0]),
        .wr_duty(wr_duty), .pwm_out(pwm1), .period_start(ps1)
    );
    pwm_multi #(.CHANNELS(4), .RES_BITS(4), .DIV(1), .STAGGER(1)) dut2 (
        .clk(clk), .reset(reset), .en(en), .wr_en(wr_sel[2]), .wr_ch(wr_ch[1:0]),
        .wr_duty(wr_duty), .pwm_out(pwm2), .period_start(ps2)
    );

    function automatic logic [20:0] expv();
        return {m_ps[2], m_pwm[2][3:0], m_ps[1], m_pwm[1][5:0], m_ps[0], m_pwm[0][7:0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_presc[k] = 0;
            m_cnt[k]   = 0;
            m_pwm[k]   = '0;
            m_ps[k]    = 1'b0;
            for (int c = 0; c < 16; c++) begin
                m_shadow[k][c] = 0;
                m_active[k][c] = 0;
            end
        end
    endtask

    // One clock edge of every instance, from the rules: output from old
    // counter/duty, period load from old shadow, then the write, then count.
    task automatic model_edge();
        bit tick, wrap;
        int ch, offs;
        for (int k = 0; k < 3; k++) begin
            tick = en && (m_presc[k] == NDIV[k] - 1);
            wrap = tick && (m_cnt[k] == P - 1);
            for (int c = 0; c < 16; c++) begin
                offs = (NSTG[k] != 0) ? (c * P) / NCH[k] : 0;
                m_pwm[k][c] = (c < NCH[k]) && en && (((m_cnt[k] + offs) % P) < m_active[k][c]);
            end
            m_ps[k] = wrap;
            if (wrap) for (int c = 0; c < 16; c++) m_active[k][c] = m_shadow[k][c];
            ch = int'(wr_ch) % (1 << NCHW[k]);
            if (wr_sel[k] && ch < NCH[k]) m_shadow[k][ch] = (int'(wr_duty) > P) ? P : int'(wr_duty);
            if (en) m_presc[k] = tick ? 0 : m_presc[k] + 1;
            if (tick) m_cnt[k] = (m_cnt[k] + 1) % P;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic write(input int k, input int ch, input int d);
        wr_sel  = 3'(1 << k);
        wr_ch   = 4'(ch);
        wr_duty = 5'(d);
        step();
        wr_sel  = '0;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        tests++;
        if (obs !== 21'h0) begin
            fails++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL reset_idle: got %h want %h", obs, expv());
            end
        end
    endtask

    task automatic test_basic();
        int hi [4];
        int n, ps_mid;
        write(0, 0, 5);
        write(0, 1, 0);
        write(0, 2, 16);
        write(0, 3, 8);
        write(1, 0, 4);
        for (int c = 0; c < 4; c++) write(2, c, 4);
        en = 1'b1;
        n = 0;
        while (!ps0 && n < 40) begin
            step();
            n++;
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL basic_wait: got %h want %h", obs, expv());
            end
        end
        tests++;
        if (!ps0) begin
            fails++;
            $display("FAIL basic_start: got no period_start within %0d cycles want one", n);
        end
        for (int c = 0; c < 4; c++) hi[c] = 0;
        ps_mid = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL basic_cycle %0d: got %h want %h", i, obs, expv());
            end
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm0[c]);
            if (i < 16) ps_mid += int'(ps0);
        end
        tests++;
        if (hi[0] != 5 || hi[1] != 0 || hi[2] != 16 || hi[3] != 8) begin
            fails++;
            $display("FAIL basic_duty: got %0d/%0d/%0d/%0d want 5/0/16/8",
                     hi[0], hi[1], hi[2], hi[3]);
        end
        tests++;
        if (ps0 !== 1'b1 || ps_mid != 0) begin
            fails++;
            $display("FAIL basic_period: got end=%b mid=%0d want end=1 mid=0", ps0, ps_mid);
        end
    endtask

    task automatic test_div3();
        int n, hi, ps_mid;
        n = 0;
        while (!ps1 && n < 100) begin
            step();
            n++;
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL div3_wait: got %h want %h", obs, expv());
            end
        end
        hi = 0;
        ps_mid = 0;
        for (int i = 1; i <= 48; i++) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL div3_cycle %0d: got %h want %h", i, obs, expv());
            end
            hi += int'(pwm1[0]);
            if (i < 48) ps_mid += int'(ps1);
        end
        tests++;
        if (hi != 12 || ps1 !== 1'b1 || ps_mid != 0) begin
            fails++;
            $display("FAIL div3_duty: got hi=%0d end=%b mid=%0d want hi=12 end=1 mid=0",
                     hi, ps1, ps_mid);
        end
    endtask

    task automatic test_wrap_write();
        int hi_a, hi_b, n;
        write(0, 0, 4);
        for (int pass = 0; pass < 2; pass++) begin
            n = 0;
            while (m_cnt[0] != P - 1 && n < 40) begin
                step();
                n++;
                tests++;
                if (obs !== expv()) begin
                    fails++;
                    $display("FAIL wrapwr_wait: got %h want %h", obs, expv());
                end
            end
            if (pass == 0) step();
        end
        write(0, 0, 10);
        tests++;
        if (ps0 !== 1'b1) begin
            fails++;
            $display("FAIL wrapwr_edge: got period_start=%b want 1", ps0);
        end
        hi_a = 0;
        hi_b = 0;
        for (int i = 1; i <= 32; i++) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL wrapwr_cycle %0d: got %h want %h", i, obs, expv());
            end
            if (i <= 16) hi_a += int'(pwm0[0]);
            else hi_b += int'(pwm0[0]);
        end
        tests++;
        if (hi_a != 4 || hi_b != 10) begin
            fails++;
            $display("FAIL wrapwr_duty: got %0d then %0d want 4 then 10", hi_a, hi_b);
        end
    endtask

    task automatic test_stagger();
        logic [3:0] s [33];
        int rise [4];
        int hi [4];
        int exp_rel [4];
        int n;
        exp_rel = '{0, 12, 8, 4};
        n = 0;
        while (!ps2 && n < 40) begin
            step();
            n++;
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL stagger_wait: got %h want %h", obs, expv());
            end
        end
        s[0] = pwm2;
        for (int j = 1; j <= 32; j++) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL stagger_cycle %0d: got %h want %h", j, obs, expv());
            end
            s[j] = pwm2;
        end
        for (int c = 0; c < 4; c++) begin
            rise[c] = -1;
            hi[c] = 0;
            for (int j = 1; j <= 32; j++) begin
                if (rise[c] < 0 && s[j][c] && !s[j-1][c]) rise[c] = j;
                if (j <= 16) hi[c] += int'(s[j][c]);
            end
        end
        tests++;
        if (rise[0] != 1) begin
            fails++;
            $display("FAIL stagger_ch0_rise: got cycle %0d want 1", rise[0]);
        end
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (((rise[c] - rise[0] + P) % P) != exp_rel[c] || hi[c] != 4) begin
                fails++;
                $display("FAIL stagger_ch%0d: got offset %0d high %0d want offset %0d high 4",
                         c, (rise[c] - rise[0] + P) % P, hi[c], exp_rel[c]);
            end
        end
    endtask

    task automatic test_write_edges();
        int hi [6];
        int hi5, n;
        write(1, 7, 9);
        write(0, 5, 31);
        repeat (40) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL edges_settle: got %h want %h", obs, expv());
            end
        end
        n = 0;
        while (!ps1 && n < 60) begin
            step();
            n++;
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL edges_wait: got %h want %h", obs, expv());
            end
        end
        for (int c = 0; c < 6; c++) hi[c] = 0;
        hi5 = 0;
        for (int i = 1; i <= 48; i++) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL edges_cycle %0d: got %h want %h", i, obs, expv());
            end
            for (int c = 0; c < 6; c++) hi[c] += int'(pwm1[c]);
            hi5 += int'(pwm0[5]);
        end
        tests++;
        if (hi[0] != 12 || (hi[1] + hi[2] + hi[3] + hi[4] + hi[5]) != 0) begin
            fails++;
            $display("FAIL edges_ignored: got ch0=%0d others=%0d want 12 and 0",
                     hi[0], hi[1] + hi[2] + hi[3] + hi[4] + hi[5]);
        end
        tests++;
        if (hi5 != 48) begin
            fails++;
            $display("FAIL edges_saturate: got %0d of 48 high want 48", hi5);
        end
    endtask

    task automatic test_enable_reset();
        int n, ones, starts;
        n = 0;
        while (m_cnt[0] != 7 && n < 40) begin
            step();
            n++;
        end
        en = 1'b0;
        repeat (20) begin
            step();
            tests++;
            if (obs !== 21'h0 || obs !== expv()) begin
                fails++;
                $display("FAIL enable_low: got %h want 0", obs);
            end
        end
        en = 1'b1;
        repeat (20) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL enable_resume: got %h want %h", obs, expv());
            end
        end
        n = 0;
        while (m_cnt[0] != 11 && n < 40) begin
            step();
            n++;
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        tests++;
        if (obs !== 21'h0) begin
            fails++;
            $display("FAIL reset_async: got %h want 0", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        ones = 0;
        starts = 0;
        repeat (40) begin
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL reset_after: got %h want %h", obs, expv());
            end
            ones += $countones({pwm2, pwm1, pwm0});
            starts += int'(ps0);
        end
        tests++;
        if (ones != 0 || starts != 2) begin
            fails++;
            $display("FAIL reset_cleared: got high=%0d starts=%0d want 0 and 2", ones, starts);
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            en      = ($urandom_range(0, 7) != 0);
            wr_sel  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
            wr_ch   = 4'($urandom_range(0, 7));
            wr_duty = 5'($urandom_range(0, 31));
            step();
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL random: got %h want %h", obs, expv());
            end
        end
        wr_sel = '0;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div3();
        test_wrap_write();
        test_stagger();
        test_write_edges();
        test_enable_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
